// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flags
// Description : Single-clock FIFO with fill count, almost-full/almost-empty
//               thresholds, optional first-word-fall-through, flush and
//               sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flags #(
    parameter int W        = 8,
    parameter int D        = 16,
    parameter bit FWFT     = 1'b0,
    parameter int AF_LEVEL = D - 2,
    parameter int AE_LEVEL = 1,
    parameter bit ERR_MSG  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   clr_err,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    output logic                   wr_full,
    output logic                   wr_almost_full,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic                   rd_empty,
    output logic                   rd_almost_empty,
    output logic [$clog2(D):0]     count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(D);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] c_DEPTH    = PW'(D);
    localparam logic [PW-1:0] c_AF_LEVEL = PW'(AF_LEVEL);
    localparam logic [PW-1:0] c_AE_LEVEL = PW'(AE_LEVEL);
    localparam logic [PW-1:0] c_ONE      = PW'(1);

    logic [W-1:0]  r_mem [D];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_count;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_raddr;

    // Flags come only from registered state, so request inputs never reach them.
    assign wr_full         = (r_count == c_DEPTH);
    assign rd_empty        = (r_count == '0);
    assign wr_almost_full  = (r_count >= c_AF_LEVEL);
    assign rd_almost_empty = (r_count <= c_AE_LEVEL);
    assign count           = r_count;
    assign overflow        = r_overflow;
    assign underflow       = r_underflow;

    assign w_wr_acc = wr_en & ~wr_full;
    assign w_rd_acc = rd_en & ~rd_empty;
    assign w_waddr  = r_wptr[AW-1:0];
    assign w_raddr  = r_rptr[AW-1:0];

    always_ff @(posedge clk) begin
        if (w_wr_acc && !flush) begin
            r_mem[w_waddr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + c_ONE;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + c_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Setting beats clearing when both happen in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && wr_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && rd_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is shown directly; forced to zero while empty so reset reads 0.
            assign rd_data = rd_empty ? '0 : r_mem[w_raddr];
        end else begin : g_registered
            logic [W-1:0] r_rd_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_data <= '0;
                end else if (w_rd_acc && !flush) begin
                    r_rd_data <= r_mem[w_raddr];
                end
            end

            assign rd_data = r_rd_data;
        end
    endgenerate

`ifndef SYNTHESIS
    generate
        if ((D < 2) || ((D & (D - 1)) != 0)) begin : g_bad_depth
            $error("sync_fifo_flags: D=%0d must be a power of two >= 2", D);
        end
    endgenerate

    always @(posedge clk) begin
        if (ERR_MSG && rst_n) begin
            if (wr_en && wr_full) begin
                $error("sync_fifo_flags: write while full");
            end
            if (rd_en && rd_empty) begin
                $error("sync_fifo_flags: read while empty");
            end
        end
    end
`endif

endmodule
`default_nettype wire
